// File: rtl/rx_slicer_arbiter.sv
// -----------------------------------------------------------------------------
// rx_slicer_arbiter
//   Shares one hard-decision slicer between NUM_CH receive channels. A
//   round-robin arbiter grants at most one channel per cycle. The granted
//   sample is sliced to +1 / -1 and registered together with its channel tag
//   and a per-channel end-of-frame flag.
//
//   Handshakes (both sides): a transfer happens on a rising clk edge where
//   valid and ready are both high; valid must not depend on ready.
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   req_valid   in   per-channel sample valid
//   req_data    in   channel c sample at [c*DATA_W +: DATA_W], two's complement
//   req_ready   out  one-hot grant (combinational, 0 while in reset)
//   out_valid   out  decision register holds a result
//   out_ready   in   downstream accepts the decision
//   out_data    out  +1 (1) or -1 (MSB only set)
//   out_ch      out  channel index of out_data
//   out_last    out  decision is the last symbol of its channel's frame
//   weak_cnt    out  saturating weak-sample count (0 unless RX_WEAK_CNT_EN)
//   o_dbg_state out  current FSM state (0 = EMPTY, 1 = FULL)
//
// Build option
//   RX_WEAK_CNT_EN : when defined, counts granted samples with |x| < WEAK_TH.
// -----------------------------------------------------------------------------
module rx_slicer_arbiter #(
  parameter int DATA_W    = 16,
  parameter int NUM_CH    = 4,
  parameter int FRAME_LEN = 64,
  parameter int WEAK_TH   = 256
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CH-1:0]           req_valid,
  input  logic [NUM_CH*DATA_W-1:0]    req_data,
  output logic [NUM_CH-1:0]           req_ready,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic [$clog2(NUM_CH)-1:0]   out_ch,
  output logic                        out_last,
  output logic [15:0]                 weak_cnt,
  output logic                        o_dbg_state
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(FRAME_LEN);

  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [CH_W-1:0]   r_rr_ptr;
  logic [CNT_W-1:0]  r_sym_cnt [NUM_CH];

  logic              w_found;
  logic [CH_W-1:0]   w_gnt_idx;
  logic [CH_W:0]     w_idx;
  logic              w_can_accept;
  logic              w_grant;
  logic [DATA_W-1:0] w_sel_data;
  logic [DATA_W-1:0] w_slice;
  logic [CH_W-1:0]   w_rr_next;
  logic              w_cnt_at_end;

  // Round-robin search: first valid channel starting at r_rr_ptr, wrapping.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_idx     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_idx = (CH_W+1)'(r_rr_ptr) + (CH_W+1)'(i);
      if (w_idx >= (CH_W+1)'(NUM_CH)) w_idx = w_idx - (CH_W+1)'(NUM_CH);
      if (!w_found && req_valid[w_idx[CH_W-1:0]]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_idx[CH_W-1:0];
      end
    end
  end

  // The output register can take a new result when empty or when the
  // current one is being drained at this same edge.
  assign w_can_accept = (r_state == S_EMPTY) || out_ready;
  assign w_grant      = w_found && w_can_accept && rst_n;
  assign req_ready    = w_grant ? (NUM_CH'(1) << w_gnt_idx) : '0;

  assign w_sel_data   = req_data[int'(w_gnt_idx)*DATA_W +: DATA_W];
  assign w_slice      = w_sel_data[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : DATA_W'(1);
  assign w_rr_next    = ({1'b0, w_gnt_idx} == (CH_W+1)'(NUM_CH-1)) ? '0 : w_gnt_idx + 1'b1;
  assign w_cnt_at_end = (r_sym_cnt[w_gnt_idx] == CNT_W'(FRAME_LEN-1));

  assign out_valid    = (r_state == S_FULL);
  assign o_dbg_state  = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_EMPTY;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_EMPTY: if (w_grant) w_next_state = S_FULL;
      S_FULL:  if (out_ready && !w_grant) w_next_state = S_EMPTY;
      default: w_next_state = S_EMPTY;
    endcase
  end

  // Datapath and per-channel frame counters only move on a grant, so a
  // stalled FULL register keeps everything frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_ch   <= '0;
      out_last <= 1'b0;
      r_rr_ptr <= '0;
      for (int c = 0; c < NUM_CH; c++) r_sym_cnt[c] <= '0;
    end else if (w_grant) begin
      out_data <= w_slice;
      out_ch   <= w_gnt_idx;
      out_last <= w_cnt_at_end;
      r_rr_ptr <= w_rr_next;
      r_sym_cnt[w_gnt_idx] <= w_cnt_at_end ? '0 : r_sym_cnt[w_gnt_idx] + 1'b1;
    end
  end

`ifdef RX_WEAK_CNT_EN
  logic [DATA_W:0] w_ext;
  logic [DATA_W:0] w_mag;
  logic [15:0]     r_weak_cnt;

  // One extra bit so the most negative sample has a representable magnitude.
  assign w_ext = {w_sel_data[DATA_W-1], w_sel_data};
  assign w_mag = w_ext[DATA_W] ? (~w_ext + 1'b1) : w_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_weak_cnt <= '0;
    end else if (w_grant && (w_mag < (DATA_W+1)'(WEAK_TH)) && (r_weak_cnt != 16'hFFFF)) begin
      r_weak_cnt <= r_weak_cnt + 16'd1;
    end
  end

  assign weak_cnt = r_weak_cnt;
`else
  assign weak_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_rx_slicer_arbiter.sv
module tb_rx_slicer_arbiter;

  localparam int DATA_W    = 16;
  localparam int NUM_CH    = 4;
  localparam int FRAME_LEN = 64;
  localparam int WEAK_TH   = 256;
  localparam int CH_W      = $clog2(NUM_CH);
  localparam int EW        = DATA_W + CH_W + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NUM_CH-1:0]        req_valid = '0;
  logic [NUM_CH*DATA_W-1:0] req_data  = '0;
  logic [NUM_CH-1:0]        req_ready;
  logic                     out_valid;
  logic                     out_ready = 1'b1;
  logic [DATA_W-1:0]        out_data;
  logic [CH_W-1:0]          out_ch;
  logic                     out_last;
  logic [15:0]              weak_cnt;
  logic                     o_dbg_state;

  rx_slicer_arbiter #(
    .DATA_W(DATA_W), .NUM_CH(NUM_CH), .FRAME_LEN(FRAME_LEN), .WEAK_TH(WEAK_TH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ch(out_ch), .out_last(out_last),
    .weak_cnt(weak_cnt), .o_dbg_state(o_dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];   // {data, ch, last} of each accepted sample, in order
  int n_cmp  = 0;
  int n_fail = 0;
  int tmo_req  = 0;
  int tmo_seen = 0;

  // Reference model: samples since reset per channel, next preferred channel,
  // whether a decision is waiting downstream, weak-sample tally.
  int m_ptr = 0;
  int m_occ = 0;
  int m_cnt [NUM_CH];
  int m_weak = 0;

  // ---------------- predictor: grants, occupancy, weak count ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      n_cmp++;
      if (req_ready !== '0 || out_valid !== 1'b0 || out_data !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs: ready=%b valid=%b data=%h, expected 0/0/0000",
                 req_ready, out_valid, out_data);
      end
      m_ptr = 0; m_occ = 0; m_weak = 0;
      for (int c = 0; c < NUM_CH; c++) m_cnt[c] = 0;
      exp_q.delete();
    end else begin
      int g;
      logic [NUM_CH-1:0] exp_ready;
      logic [DATA_W-1:0] s;
      logic [DATA_W-1:0] dec;
      if (tmo_req != tmo_seen) begin
        n_cmp++; n_fail++;
        $display("FAIL handshake_timeout: no grant within bound (%0d timeouts)", tmo_req);
        tmo_seen = tmo_req;
      end
      g = -1;
      exp_ready = '0;
      if (m_occ == 0 || out_ready) begin
        for (int i = 0; i < NUM_CH; i++) begin
          int c;
          c = (m_ptr + i) % NUM_CH;
          if (g < 0 && req_valid[c]) g = c;
        end
      end
      if (g >= 0) exp_ready[g] = 1'b1;
      n_cmp++;
      if (req_ready !== exp_ready) begin
        n_fail++;
        $display("FAIL grant: req_ready=%b expected %b (ptr=%0d valid=%b)", req_ready, exp_ready, m_ptr, req_valid);
      end
      n_cmp++;
      if (out_valid !== (m_occ != 0)) begin
        n_fail++;
        $display("FAIL out_valid: got %b expected %0d", out_valid, m_occ);
      end
      n_cmp++;
      if (weak_cnt !== 16'(m_weak)) begin
        n_fail++;
        $display("FAIL weak_cnt: got %0d expected %0d", weak_cnt, m_weak);
      end
      if (g >= 0) begin
        s   = req_data[g*DATA_W +: DATA_W];
        dec = ($signed(s) < 0) ? 16'h8000 : 16'h0001;
        exp_q.push_back({dec, CH_W'(g), ((m_cnt[g] % FRAME_LEN) == FRAME_LEN-1)});
        m_cnt[g]++;
        m_ptr = (g + 1) % NUM_CH;
`ifdef RX_WEAK_CNT_EN
        begin
          int v;
          v = int'($signed(s));
          if (v < 0) v = -v;
          if (v < WEAK_TH && m_weak < 65535) m_weak++;
        end
`endif
      end
      m_occ = (g >= 0 || (m_occ != 0 && !out_ready)) ? 1 : 0;
    end
  end

  // ---------------- monitor: output register vs expected queue ----------------
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL out_unexpected: data=%h ch=%0d last=%b with nothing expected", out_data, out_ch, out_last);
      end else begin
        if ({out_data, out_ch, out_last} !== exp_q[0]) begin
          n_fail++;
          $display("FAIL out_result: got data=%h ch=%0d last=%b expected data=%h ch=%0d last=%b",
                   out_data, out_ch, out_last,
                   exp_q[0][EW-1 -: DATA_W], exp_q[0][CH_W:1], exp_q[0][0]);
        end
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input logic [NUM_CH-1:0] valid_during);
    @(posedge clk); #1;
    rst_n = 1'b0;
    req_valid = valid_during;
    repeat (3) @(posedge clk);
    #1;
    req_valid = '0;
    rst_n = 1'b1;
  endtask

  task automatic send(input int ch, input logic [DATA_W-1:0] v);
    bit ok;
    req_valid[ch] = 1'b1;
    req_data[ch*DATA_W +: DATA_W] = v;
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (req_ready[ch]) ok = 1'b1;
    end
    @(posedge clk); #1;
    req_valid[ch] = 1'b0;
    if (!ok) tmo_req++;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DATA_W-1:0] slice_vals [4];
    logic [DATA_W-1:0] weak_vals [4];
    slice_vals = '{16'h7FFF, 16'h0000, 16'hFFFF, 16'h8000};
    weak_vals  = '{16'd100, 16'hFF01, 16'd256, 16'h8000};

    // Reset with every channel requesting; first grant after release is ch0.
    rst_n = 1'b0;
    req_valid = '1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    req_valid = '0;
    repeat (2) @(posedge clk);

    // Slicing on ch1, back to back.
    #1;
    for (int i = 0; i < 4; i++) send(1, slice_vals[i]);
    repeat (2) @(posedge clk);

    // Round robin from a clean pointer.
    do_reset('0);
    req_valid = '1;
    for (int c = 0; c < NUM_CH; c++) req_data[c*DATA_W +: DATA_W] = DATA_W'($urandom);
    repeat (6) @(posedge clk);
    #1 req_valid = '0;
    repeat (2) @(posedge clk);

    // Backpressure: ch2 sends -5, then three stalled cycles with ch3 waiting.
    #1;
    send(2, 16'hFFFB);
    out_ready = 1'b0;
    req_valid[3] = 1'b1;
    req_data[3*DATA_W +: DATA_W] = 16'd42;
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b1;
    send(3, 16'd42);
    repeat (2) @(posedge clk);

    // Frame wrap on ch0: 130 samples from a fresh reset.
    do_reset('0);
    for (int i = 0; i < 130; i++) send(0, DATA_W'($urandom));
    // Reset mid-frame, then a full frame again.
    for (int i = 0; i < 10; i++) send(0, DATA_W'($urandom));
    do_reset('0);
    for (int i = 0; i < 66; i++) send(0, DATA_W'($urandom));
    repeat (2) @(posedge clk);

    // Weak-sample counting.
    do_reset('0);
    for (int i = 0; i < 4; i++) send(i % NUM_CH, weak_vals[i]);
    repeat (3) @(posedge clk);

    // Random traffic with random backpressure.
    for (int n = 0; n < 2000; n++) begin
      #1;
      req_valid = NUM_CH'($urandom_range(0, (1 << NUM_CH) - 1));
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(0, 1) == 0)
          req_data[c*DATA_W +: DATA_W] = DATA_W'(int'($urandom_range(0, 1023)) - 512);
        else
          req_data[c*DATA_W +: DATA_W] = DATA_W'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
    end
    #1;
    req_valid = '0;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
